// File: rtl/voice_allocator.sv
// voice_allocator
//   Polyphony controller: maps up to NVOICES held keys from the PS/2 key
//   decoder onto a bank of shared sine generators. A 3-bit scan pointer
//   visits one key per clock, so a full sweep takes 8 cycles and any key
//   change reaches the outputs within 9 cycles (1 input register + sweep).
//
//   Optional feature macro: VOICE_STEAL_EN
//     defined   : a press with all slots busy steals the oldest slot
//                 (lowest index on an age tie); the evicted key is flagged
//                 in dropped and stays silent until released and re-pressed.
//     undefined : a press with all slots busy is flagged in dropped and
//                 stays silent until released and re-pressed.
//
// Ports
//   clk        in   system clock (key decoder domain)
//   clrn       in   asynchronous active-low reset
//   key_8      in   [7:0]  level per key, bit k = key k held
//   voice_on   out  [NVOICES-1:0]     slot i active
//   voice_freq out  [16*NVOICES-1:0]  slot i frequency word at [16i+15:16i]
//   voice_key  out  [3*NVOICES-1:0]   key index owning slot i
//   voice_cnt  out  [3:0]  number of active slots
//   dropped    out  [7:0]  key held but not sounding
module voice_allocator #(
  parameter int NVOICES = 4,
  parameter int AGE_W   = 3
) (
  input  logic                   clk,
  input  logic                   clrn,
  input  logic [7:0]             key_8,
  output logic [NVOICES-1:0]     voice_on,
  output logic [16*NVOICES-1:0]  voice_freq,
  output logic [3*NVOICES-1:0]   voice_key,
  output logic [3:0]             voice_cnt,
  output logic [7:0]             dropped
);

  localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;

  function automatic logic [15:0] freq_of(input logic [2:0] k);
    case (k)
      3'd0:    freq_of = 16'd714;
      3'd1:    freq_of = 16'd802;
      3'd2:    freq_of = 16'd900;
      3'd3:    freq_of = 16'd954;
      3'd4:    freq_of = 16'd1070;
      3'd5:    freq_of = 16'd1201;
      3'd6:    freq_of = 16'd1349;
      default: freq_of = 16'd1429;
    endcase
  endfunction

  logic [2:0]            ptr;
  logic [7:0]            key_q;
  logic [7:0]            h_q;
  logic [AGE_W-1:0]      age_q [NVOICES];

  logic [NVOICES-1:0]    on_n;
  logic [16*NVOICES-1:0] freq_n;
  logic [3*NVOICES-1:0]  key_n;
  logic [7:0]            drop_n;
  logic [7:0]            h_n;
  logic [AGE_W-1:0]      age_n [NVOICES];
  logic [3:0]            cnt_n;
  logic                  press, rel, free_found, own_found, do_alloc;
  logic [IW-1:0]         free_idx, own_idx, tgt;
`ifdef VOICE_STEAL_EN
  logic [IW-1:0]         steal_idx;
  logic [2:0]            steal_key;
`endif

  always_comb begin
    on_n       = voice_on;
    freq_n     = voice_freq;
    key_n      = voice_key;
    drop_n     = dropped;
    h_n        = h_q;
    age_n      = age_q;
    cnt_n      = '0;
    free_found = 1'b0;
    free_idx   = '0;
    own_found  = 1'b0;
    own_idx    = '0;
    tgt        = '0;
    do_alloc   = 1'b0;
    press      = key_q[ptr] & ~h_q[ptr];
    rel        = ~key_q[ptr] & h_q[ptr];

    // Descending scan so the lowest-index free slot is the one that sticks.
    for (int i = NVOICES - 1; i >= 0; i--) begin
      if (!voice_on[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end

    for (int i = 0; i < NVOICES; i++) begin
      if (voice_on[i] && voice_key[3*i +: 3] == ptr) begin
        own_found = 1'b1;
        own_idx   = IW'(i);
      end
    end

`ifdef VOICE_STEAL_EN
    // Strict greater-than keeps the lowest index on an age tie.
    steal_idx = '0;
    steal_key = voice_key[2:0];
    for (int i = 1; i < NVOICES; i++) begin
      if (age_q[i] > age_q[steal_idx]) begin
        steal_idx = IW'(i);
        steal_key = voice_key[3*i +: 3];
      end
    end
`endif

    if (press) begin
      h_n[ptr] = 1'b1;
      if (free_found) begin
        tgt      = free_idx;
        do_alloc = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        tgt               = steal_idx;
        do_alloc          = 1'b1;
        drop_n[steal_key] = 1'b1;
`else
        drop_n[ptr] = 1'b1;
`endif
      end
    end else if (rel) begin
      h_n[ptr]    = 1'b0;
      drop_n[ptr] = 1'b0;
      if (own_found) begin
        on_n[own_idx]  = 1'b0;
        age_n[own_idx] = '0;
      end
    end

    if (do_alloc) begin
      for (int i = 0; i < NVOICES; i++) begin
        if (IW'(i) == tgt) begin
          on_n[i]            = 1'b1;
          key_n[3*i +: 3]    = ptr;
          freq_n[16*i +: 16] = freq_of(ptr);
          age_n[i]           = '0;
        end else if (voice_on[i] && age_q[i] != {AGE_W{1'b1}}) begin
          age_n[i] = age_q[i] + AGE_W'(1);
        end
      end
    end

    for (int i = 0; i < NVOICES; i++) begin
      cnt_n = cnt_n + 4'(on_n[i]);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ptr        <= '0;
      key_q      <= '0;
      h_q        <= '0;
      voice_on   <= '0;
      voice_freq <= '0;
      voice_key  <= '0;
      voice_cnt  <= '0;
      dropped    <= '0;
      for (int i = 0; i < NVOICES; i++) age_q[i] <= '0;
    end else begin
      ptr        <= ptr + 3'd1;
      key_q      <= key_8;
      h_q        <= h_n;
      voice_on   <= on_n;
      voice_freq <= freq_n;
      voice_key  <= key_n;
      voice_cnt  <= cnt_n;
      dropped    <= drop_n;
      for (int i = 0; i < NVOICES; i++) age_q[i] <= age_n[i];
    end
  end

endmodule
